// File: rtl/bloco_controle.sv
// rtl/bloco_controle.sv - instruction sequencer driving the BLOCO register-bank/ALU/flag datapath
// Optional repeat of each instruction is built only when BLOCO_CTRL_REPEAT_EN is defined.
module bloco_controle #(
  parameter int end_registros = 2,
  parameter int CLR_CICLOS    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  input  logic [15:0]              instr,
  output logic                     instr_ready,
  input  logic                     halt,
  output logic                     Hab_Escrita,
  output logic [end_registros-1:0] Sel_SA,
  output logic [end_registros-1:0] Sel_SB,
  output logic [end_registros-1:0] Sel_SC,
  output logic [4:0]               controleOperacao,
  output logic                     reset_Ban_Registros,
  output logic                     reset_Flags,
  output logic                     busy,
  output logic [15:0]              instr_count
);

  localparam int CW = (CLR_CICLOS > 1) ? $clog2(CLR_CICLOS) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CICLOS - 1);
  localparam logic [4:0] OP_CLEAR = 5'b11111;

  typedef enum logic [1:0] {CLR, IDLE, EXEC} state_t;

  state_t        state_q;
  logic [CW-1:0] clr_cnt_q;
  logic          clr_op_q;
  logic [15:4]   ir_q;
  logic [15:0]   instr_count_q;
`ifdef BLOCO_CTRL_REPEAT_EN
  logic [3:0]    rep_cnt_q;
`else
  logic          unused_rep;
  assign unused_rep = ^instr[3:0];
`endif

  // Datapath controls come straight from registers: no input-to-output paths except halt->ready.
  assign instr_ready         = (state_q == IDLE) && !halt;
  assign busy                = (state_q != IDLE);
  assign reset_Ban_Registros = (state_q == CLR);
  assign reset_Flags         = (state_q == CLR);
  assign Hab_Escrita         = (state_q == EXEC) && ir_q[4];
  assign controleOperacao    = ir_q[15:11];
  assign Sel_SA              = ir_q[10:9];
  assign Sel_SB              = ir_q[8:7];
  assign Sel_SC              = ir_q[6:5];
  assign instr_count         = instr_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= CLR;
      clr_cnt_q     <= '0;
      clr_op_q      <= 1'b0;
      ir_q          <= '0;
      instr_count_q <= '0;
`ifdef BLOCO_CTRL_REPEAT_EN
      rep_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        CLR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            clr_op_q  <= 1'b0;
            // Only an opcode-requested clear retires as an instruction.
            if (clr_op_q) instr_count_q <= instr_count_q + 16'd1;
          end else begin
            clr_cnt_q <= clr_cnt_q + CW'(1);
          end
        end
        IDLE: begin
          if (instr_valid && instr_ready) begin
            ir_q <= instr[15:4];
            if (instr[15:11] == OP_CLEAR) begin
              state_q  <= CLR;
              clr_op_q <= 1'b1;
            end else begin
              state_q <= EXEC;
`ifdef BLOCO_CTRL_REPEAT_EN
              rep_cnt_q <= instr[3:0];
`endif
            end
          end
        end
        EXEC: begin
`ifdef BLOCO_CTRL_REPEAT_EN
          if (rep_cnt_q == 4'd0) begin
            state_q       <= IDLE;
            instr_count_q <= instr_count_q + 16'd1;
          end else begin
            rep_cnt_q <= rep_cnt_q - 4'd1;
          end
`else
          state_q       <= IDLE;
          instr_count_q <= instr_count_q + 16'd1;
`endif
        end
        default: state_q <= CLR;
      endcase
    end
  end

endmodule

// File: tb/tb_bloco_controle.sv
// tb/tb_bloco_controle.sv - scoreboard bench for bloco_controle (EXEC cycles and retire count)
module tb_bloco_controle;

`ifdef BLOCO_CTRL_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        halt = 1'b0;
  logic        instr_ready, Hab_Escrita, reset_Ban_Registros, reset_Flags, busy;
  logic [1:0]  Sel_SA, Sel_SB, Sel_SC;
  logic [4:0]  controleOperacao;
  logic [15:0] instr_count;

  int total = 0;
  int bad = 0;
  int exp_count = 0;
  logic [11:0] exec_q[$];
  logic [15:0] cnt_q[$];

  bloco_controle #(.end_registros(2), .CLR_CICLOS(2)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .halt(halt), .Hab_Escrita(Hab_Escrita),
    .Sel_SA(Sel_SA), .Sel_SB(Sel_SB), .Sel_SC(Sel_SC),
    .controleOperacao(controleOperacao), .reset_Ban_Registros(reset_Ban_Registros),
    .reset_Flags(reset_Flags), .busy(busy), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] sc, input logic wb, input logic [3:0] rep);
    return {op, sa, sb, sc, wb, rep};
  endfunction

  // Expected per-EXEC-cycle record: {wb, sa, sb, sc, op}
  function automatic logic [11:0] exp_exec(input logic [15:0] w);
    return {w[4], w[10:9], w[8:7], w[6:5], w[15:11]};
  endfunction

  function automatic int n_exec(input logic [15:0] w);
    return (REP_ON != 0) ? int'(w[3:0]) + 1 : 1;
  endfunction

  // Monitor: every EXEC cycle (busy, not clearing) consumes one expected record.
  logic [15:0] prev_count = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_count = '0;
    end else begin
      if (busy && !reset_Ban_Registros) begin
        if (exec_q.size() == 0) begin
          check("unexpected_exec", 32'(controleOperacao), 32'h1ff);
        end else begin
          logic [11:0] e;
          e = exec_q.pop_front();
          check("exec_cycle", 32'({Hab_Escrita, Sel_SA, Sel_SB, Sel_SC, controleOperacao}), 32'(e));
        end
      end
      if (instr_count != prev_count) begin
        if (cnt_q.size() == 0) begin
          check("unexpected_retire", 32'(instr_count), 32'hfffff);
        end else begin
          check("instr_count", 32'(instr_count), 32'(cnt_q.pop_front()));
        end
        prev_count = instr_count;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [15:0] w, input bit push);
    if (push) begin
      if (w[15:11] != 5'b11111)
        for (int i = 0; i < n_exec(w); i++) exec_q.push_back(exp_exec(w));
      exp_count++;
      cnt_q.push_back(16'(exp_count));
    end
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 50 && !instr_ready; i++) @(negedge clk);
    check("send_ready_timeout", 32'(instr_ready), 32'h1);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic check_clr_release(input string tag);
    @(negedge clk);
    check({tag, "_clr_edge1"}, 32'({reset_Ban_Registros, reset_Flags, instr_ready}), 32'b110);
    @(negedge clk);
    check({tag, "_clr_done"}, 32'({reset_Ban_Registros, reset_Flags, instr_ready, busy}), 32'b0010);
    check({tag, "_count0"}, 32'(instr_count), 32'h0);
  endtask

  initial begin
    int hab_n, nr_n, clr_n;
    logic [15:0] w;
    @(negedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({Hab_Escrita, Sel_SA, Sel_SB, Sel_SC, controleOperacao, instr_ready}), 32'h0);
    check("rst_flags", 32'({busy, reset_Ban_Registros, reset_Flags}), 32'b111);
    check("rst_count", 32'(instr_count), 32'h0);
    reset = 1'b1;
    check_clr_release("post_reset");

    // Single write, no repeat
    send(16'h0A90, 1'b1);
    check("a90_exec", 32'({Hab_Escrita, Sel_SA, controleOperacao, instr_ready}), 32'({1'b1, 2'd1, 5'd1, 1'b0}));
    @(negedge clk);
    check("a90_idle", 32'({Hab_Escrita, instr_ready, busy}), 32'b010);
    check("a90_count", 32'(instr_count), 32'h1);

    // Repeat of 3 with write enable
    w = mk(5'd2, 2'd2, 2'd3, 2'd1, 1'b1, 4'd3);
    send(w, 1'b1);
    hab_n = 0; nr_n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (Hab_Escrita) hab_n++;
      if (!instr_ready) nr_n++;
      @(negedge clk);
    end
    check("rep3_hab_cycles", 32'(hab_n), 32'(n_exec(w)));
    check("rep3_notready_cycles", 32'(nr_n), 32'(n_exec(w)));

    // Repeat with wb=0: EXEC cycles must not write
    w = mk(5'd3, 2'd1, 2'd0, 2'd2, 1'b0, 4'd2);
    send(w, 1'b1);
    hab_n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (Hab_Escrita) hab_n++;
      @(negedge clk);
    end
    check("wb0_hab_cycles", 32'(hab_n), 32'h0);

    // Clear opcode (wb bit set, must still not write)
    send(mk(5'd31, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0), 1'b1);
    clr_n = 0; hab_n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (reset_Ban_Registros && reset_Flags) clr_n++;
      if (Hab_Escrita) hab_n++;
      @(negedge clk);
    end
    check("clr_op_cycles", 32'(clr_n), 32'h2);
    check("clr_op_hab", 32'(hab_n), 32'h0);
    check("clr_op_count", 32'(instr_count), 32'h4);

    // Halt raised during a repeat; a held valid waits until halt falls
    send(mk(5'd4, 2'd0, 2'd1, 2'd2, 1'b1, 4'd3), 1'b1);
    halt = 1'b1;
    w = mk(5'd6, 2'd3, 2'd2, 2'd1, 1'b1, 4'd0);
    instr = w;
    instr_valid = 1'b1;
    nr_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_ready) nr_n++;
      @(negedge clk);
    end
    check("halt_ready_low", 32'(nr_n), 32'h0);
    check("halt_idle", 32'({busy, instr_count}), 32'({1'b0, 16'd5}));
    exec_q.push_back(exp_exec(w));
    exp_count++;
    cnt_q.push_back(16'(exp_count));
    halt = 1'b0;
    #1;
    check("unhalt_ready", 32'(instr_ready), 32'h1);
    @(negedge clk);
    instr_valid = 1'b0;
    check("unhalt_accept", 32'({busy, Hab_Escrita, Sel_SA}), 32'({1'b1, 1'b1, 2'd3}));
    @(negedge clk);

    // Reset pulse during a rep=5 instruction
    w = mk(5'd5, 2'd1, 2'd2, 2'd3, 1'b1, 4'd5);
    exec_q.push_back(exp_exec(w));
    send(w, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midrst_outputs", 32'({Hab_Escrita, Sel_SA, Sel_SB, Sel_SC, controleOperacao, instr_ready}), 32'h0);
    check("midrst_flags", 32'({busy, reset_Ban_Registros, reset_Flags}), 32'b111);
    check("midrst_count", 32'(instr_count), 32'h0);
    exp_count = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_clr_release("midrst");

    send(mk(5'd7, 2'd2, 2'd1, 2'd0, 1'b1, 4'd0), 1'b1);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("final_count", 32'(instr_count), 32'h1);
    @(negedge clk);
    check("exec_q_empty", 32'(exec_q.size()), 32'h0);
    check("cnt_q_empty", 32'(cnt_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
